// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared memory access types, arbiter owner tag and alignment helper
package mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    // Access size in load/store funct3 encoding
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_addr_t;

    // Which requester owns the read response arriving next cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_EXT  = 2'd2
    } arb_owner_t;

    // Only the two low address bits decide natural alignment
    function automatic logic mem_aligned(input logic [1:0] addr_lo, input mem_addr_t size);
        case (size)
            MEM_W:         return (addr_lo == 2'b00);
            MEM_H, MEM_HU: return (addr_lo[0] == 1'b0);
            default:       return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_starve.sv
// rtl/mem_arb_starve.sv - saturating starvation counter that promotes the external master
module mem_arb_starve #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ext_req,
    input  logic ext_gnt,
    output logic ext_pri
);

    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;

    // Count consecutive ungranted ext requests, hold at the limit, clear on grant or idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (ext_req && !ext_gnt) begin
            if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    assign ext_pri = (STARVE_LIMIT != 0) && (starve_cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - core/external master arbiter for the single memory port (optional MEM_ARB_EXT_HALT_EN)
import mem_arbiter_pkg::*;

module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  mem_addr_t         core_size,
    input  word_t             core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic              core_err,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  mem_addr_t         ext_size,
    input  word_t             ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic              ext_err,
`ifdef MEM_ARB_EXT_HALT_EN
    input  logic              ext_halt,
    output logic              core_halted,
`endif
    output word_t             rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output mem_addr_t         mem_size,
    output word_t             mem_wdata,
    input  word_t             mem_rdata
);

    logic              ext_pri;
    logic              halt;
    logic              any_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    mem_addr_t         sel_size;
    word_t             sel_wdata;
    logic              aligned;
    arb_owner_t        owner;
    arb_owner_t        owner_next;
    logic              core_err_r;
    logic              ext_err_r;

`ifdef MEM_ARB_EXT_HALT_EN
    assign halt = ext_halt;
`else
    assign halt = 1'b0;
`endif

    mem_arb_starve #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk    (clk),
        .rst_n  (rst_n),
        .ext_req(ext_req),
        .ext_gnt(ext_gnt),
        .ext_pri(ext_pri)
    );

    // Same-cycle grant: promoted or halting ext first, then core, then ext; nothing in reset
    always_comb begin
        core_gnt = 1'b0;
        ext_gnt  = 1'b0;
        if (rst_n) begin
            if ((ext_pri || halt) && ext_req) begin
                ext_gnt = 1'b1;
            end else if (core_req && !halt) begin
                core_gnt = 1'b1;
            end else if (ext_req) begin
                ext_gnt = 1'b1;
            end
        end
    end

    // Steer the winner onto the memory port; misaligned grants are consumed without an access
    always_comb begin
        any_gnt   = core_gnt || ext_gnt;
        sel_we    = ext_gnt ? ext_we    : core_we;
        sel_addr  = ext_gnt ? ext_addr  : core_addr;
        sel_size  = ext_gnt ? ext_size  : core_size;
        sel_wdata = ext_gnt ? ext_wdata : core_wdata;
        aligned   = mem_aligned(sel_addr[1:0], sel_size);
        mem_en    = any_gnt && aligned;
        mem_we    = mem_en && sel_we;
        mem_addr  = sel_addr;
        mem_size  = sel_size;
        mem_wdata = sel_wdata;
        owner_next = OWN_NONE;
        if (mem_en && !sel_we) begin
            owner_next = ext_gnt ? OWN_EXT : OWN_CORE;
        end
    end

    // Remember who owns next cycle's read data and who gets a misalignment pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner      <= OWN_NONE;
            core_err_r <= 1'b0;
            ext_err_r  <= 1'b0;
        end else begin
            owner      <= owner_next;
            core_err_r <= core_gnt && !aligned;
            ext_err_r  <= ext_gnt && !aligned;
        end
    end

    // Responses are masked while reset is held so an in-flight read is dropped
    assign core_rvalid = rst_n && (owner == OWN_CORE);
    assign ext_rvalid  = rst_n && (owner == OWN_EXT);
    assign core_err    = rst_n && core_err_r;
    assign ext_err     = rst_n && ext_err_r;
    assign rdata       = mem_rdata;

`ifdef MEM_ARB_EXT_HALT_EN
    // Core cannot be granted while halted, so once its pending read drains it stays drained
    assign core_halted = rst_n && ext_halt && (owner != OWN_CORE);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with reference model and SRAM model
`timescale 1ns/1ps
import mem_arbiter_pkg::*;

module tb_mem_arbiter;

    localparam int L = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_we, ext_req, ext_we;
    logic [31:0] core_addr, ext_addr, mem_addr;
    mem_addr_t   core_size, ext_size, mem_size;
    word_t       core_wdata, ext_wdata, mem_wdata, rdata, mem_rdata;
    logic        core_gnt, core_rvalid, core_err, ext_gnt, ext_rvalid, ext_err;
    logic        mem_en, mem_we;
    logic        ext_halt;
    logic        core_halted;

    int total = 0;
    int bad   = 0;

    word_t sram   [16];
    word_t shadow [16];

    int    m_cnt;
    bit    m_rvc, m_rve, m_erc, m_ere;
    word_t m_rd;

    mem_addr_t sizes [5] = '{MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU};

    mem_arbiter #(.STARVE_LIMIT(L), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_size(core_size), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_err(core_err),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_size(ext_size), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_err(ext_err),
`ifdef MEM_ARB_EXT_HALT_EN
        .ext_halt(ext_halt), .core_halted(core_halted),
`endif
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_size(mem_size), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

`ifndef MEM_ARB_EXT_HALT_EN
    assign core_halted = 1'b0;
`endif

    always #5 clk = ~clk;

    // Synchronous SRAM with one-cycle read latency, word granular
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr[5:2]] <= mem_wdata;
            else        mem_rdata <= sram[mem_addr[5:2]];
        end
    end

    function automatic bit aligned_ref(input logic [31:0] a, input mem_addr_t s);
        if (s == MEM_W) return (a % 4) == 0;
        if (s == MEM_H || s == MEM_HU) return (a % 2) == 0;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Check one cycle against the model (called at the negedge after inputs are driven)
    task automatic cyc();
        bit pri, ew, cw, al, en, we, r, h;
        logic [31:0] a;
        mem_addr_t sz;
        word_t wd;
        #1;
        r   = rst_n;
        h   = ext_halt;
`ifndef MEM_ARB_EXT_HALT_EN
        h   = 1'b0;
`endif
        pri = (L != 0) && (m_cnt == L);
        ew  = r && ext_req && (pri || h || !core_req);
        cw  = r && core_req && !ew && !h;
        we  = ew ? ext_we    : core_we;
        a   = ew ? ext_addr  : core_addr;
        sz  = ew ? ext_size  : core_size;
        wd  = ew ? ext_wdata : core_wdata;
        al  = aligned_ref(a, sz);
        en  = (cw || ew) && al;
        chk("core_gnt", core_gnt, cw);
        chk("ext_gnt", ext_gnt, ew);
        chk("mem_en", mem_en, en);
        chk("mem_we", mem_we, (en && we));
        if (en) begin
            chk("mem_addr", mem_addr, a);
            chk("mem_size", mem_size, sz);
            if (we) chk("mem_wdata", mem_wdata, wd);
        end
        chk("core_rvalid", core_rvalid, (r && m_rvc));
        chk("ext_rvalid", ext_rvalid, (r && m_rve));
        chk("core_err", core_err, (r && m_erc));
        chk("ext_err", ext_err, (r && m_ere));
        if (r && (m_rvc || m_rve)) chk("rdata", rdata, m_rd);
`ifdef MEM_ARB_EXT_HALT_EN
        chk("core_halted", core_halted, (r && h && !m_rvc));
`endif
        @(posedge clk);
        if (!r) begin
            m_cnt = 0; m_rvc = 0; m_rve = 0; m_erc = 0; m_ere = 0;
        end else begin
            if (ext_req && !ew) m_cnt = (m_cnt < L) ? m_cnt + 1 : L;
            else                m_cnt = 0;
            m_rvc = cw && al && !we;
            m_rve = ew && al && !we;
            m_erc = cw && !al;
            m_ere = ew && !al;
            if (en && !we) m_rd = shadow[a[5:2]];
            if (en && we)  shadow[a[5:2]] = wd;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        core_req = 0; ext_req = 0; ext_halt = 0;
    endtask

    task automatic set_core(input bit we, input logic [31:0] a, input mem_addr_t s, input word_t d);
        core_req = 1; core_we = we; core_addr = a; core_size = s; core_wdata = d;
    endtask

    task automatic set_ext(input bit we, input logic [31:0] a, input mem_addr_t s, input word_t d);
        ext_req = 1; ext_we = we; ext_addr = a; ext_size = s; ext_wdata = d;
    endtask

    initial begin
        int first_ext;
        for (int i = 0; i < 16; i++) begin
            sram[i]   = $urandom;
            shadow[i] = sram[i];
        end
        sram[0] = 32'hDEADBEEF; shadow[0] = 32'hDEADBEEF;
        mem_rdata = '0;
        m_cnt = 0; m_rvc = 0; m_rve = 0; m_erc = 0; m_ere = 0; m_rd = '0;
        rst_n = 0; ext_halt = 0;
        set_core(0, 32'h0, MEM_W, 0);
        set_ext(0, 32'h4, MEM_W, 0);
        @(negedge clk);

        // Requests during reset must not be granted
        cyc(); cyc();
        rst_n = 1; idle();
        cyc();

        // Core-only word read of 0x100
        set_core(0, 32'h100, MEM_W, 0);
        cyc();
        idle();
        #1;
        chk("t1_rvalid", core_rvalid, 1'b1);
        chk("t1_rdata", rdata, 32'hDEADBEEF);
        chk("t1_ext_rvalid", ext_rvalid, 1'b0);
        cyc();

        // Both requesting continuously: ext promoted in cycle L
        first_ext = -1;
        set_core(0, 32'h0C, MEM_W, 0);
        set_ext(0, 32'h08, MEM_W, 0);
        for (int i = 0; i < 11; i++) begin
            #1;
            if (ext_gnt && first_ext < 0) first_ext = i;
            cyc();
        end
        chk("t2_first_ext_gnt", first_ext, L);
        idle(); cyc();

        // Misaligned word store
        set_core(1, 32'h102, MEM_W, 32'h12345678);
        #1;
        chk("t3_gnt", core_gnt, 1'b1);
        chk("t3_mem_en", mem_en, 1'b0);
        cyc();
        idle();
        #1;
        chk("t3_err", core_err, 1'b1);
        cyc(); cyc();

        // Ext read then core read, responses in order
        set_ext(0, 32'h40, MEM_W, 0);
        cyc();
        idle();
        set_core(0, 32'h44, MEM_W, 0);
        cyc();
        idle();
        cyc(); cyc();

        // Reset while a core read is in flight
        set_core(0, 32'h48, MEM_W, 0);
        cyc();
        idle(); rst_n = 0;
        set_ext(0, 32'h4C, MEM_B, 0);
        cyc(); cyc();
        rst_n = 1; idle();
        set_core(0, 32'h48, MEM_W, 0);
        cyc();
        idle(); cyc();

`ifdef MEM_ARB_EXT_HALT_EN
        // Halt while a core read is in flight
        set_core(0, 32'h50, MEM_W, 0);
        cyc();
        ext_halt = 1;
        cyc(); cyc(); cyc();
        ext_halt = 0; idle();
        cyc();
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst_n     = ($urandom_range(0, 59) != 0);
            core_req  = ($urandom_range(0, 9) < 6);
            ext_req   = ($urandom_range(0, 9) < 5);
            core_we   = $urandom_range(0, 1);
            ext_we    = $urandom_range(0, 1);
            core_addr = {$urandom_range(0, 3), 2'b00, 6'($urandom)};
            ext_addr  = {$urandom_range(0, 3), 2'b00, 6'($urandom)};
            core_size = sizes[$urandom_range(0, 4)];
            ext_size  = sizes[$urandom_range(0, 4)];
            core_wdata = $urandom;
            ext_wdata  = $urandom;
`ifdef MEM_ARB_EXT_HALT_EN
            ext_halt  = ($urandom_range(0, 9) == 0);
`endif
            cyc();
        end
        rst_n = 1; idle(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single synchronous memory port between the core datapath (fetch, load and store) and an external master (debug/loader).
- Core has default priority. The external master is promoted after a bounded starvation window.
- Sits between the datapath memory interface and the SRAM wrapper. core_gnt acts as the core's stall signal.

Parameters:
- STARVE_LIMIT, 8: consecutive ungranted ext_req cycles before ext is given priority; 0 means strict core priority.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- core_req  in  1  core requests an access this cycle
- core_we  in  1  1 = store, 0 = read
- core_addr  in  ADDR_W  byte address
- core_size  in  mem_addr_t  access size (f3 encoding)
- core_wdata  in  32  store data
- core_gnt  out  1  core access accepted this cycle
- core_rvalid  out  1  core read data valid on rdata
- core_err  out  1  core misaligned access reported
- ext_req, ext_we, ext_addr, ext_size, ext_wdata  in  as core_*  external master request
- ext_gnt, ext_rvalid, ext_err  out  1 each  as core_*
- rdata  out  32  broadcast read data (= mem_rdata)
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_size  out  mem_addr_t  memory access size
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid one cycle after a read

Behaviour:
- Grant is combinational and same-cycle. At most one of core_gnt/ext_gnt is high. A gnt is only ever high while its req is high.
- Arbitration:
  - ext_pri = (STARVE_LIMIT != 0) && (starve_cnt == STARVE_LIMIT).
  - If ext_pri && ext_req: ext wins.
  - Else if core_req: core wins.
  - Else if ext_req: ext wins.
- Starvation counter:
  - starve_cnt increments each cycle ext_req=1 && ext_gnt=0, saturating at STARVE_LIMIT.
  - It clears when ext_gnt=1 or ext_req=0.
- Granted access:
  - mem_en=1 and the mem_* outputs are driven from the winner's inputs in the same cycle.
  - With no grant: mem_en=0, mem_we=0, other mem_* don't-care.
- Alignment check:
  - MEM_W requires addr[1:0]==0. MEM_H/MEM_HU require addr[0]==0. Byte sizes are always aligned.
  - A misaligned request is still granted (consumed), but mem_en=0.
  - The winner's *_err pulses for 1 cycle on the next cycle.
- Read response:
  - A registered owner tag (arb_owner_t) records the winner of an accepted aligned read.
  - On the following cycle the matching *_rvalid=1 for exactly 1 cycle and rdata=mem_rdata.
  - Writes produce no rvalid.
- Back-to-back accesses are allowed every cycle. An rvalid for access N coexists with the grant for access N+1.
- Reset (rst_n=0 at a clock edge):
  - owner tag=OWN_NONE, starve_cnt=0, all err/rvalid=0.
  - While rst_n=0, gnt and mem_en are forced to 0 combinationally.
  - A read in flight when reset asserts gets no rvalid.
- Simultaneous requests below the limit: core wins. ext_req held continuously is granted no later than cycle STARVE_LIMIT+1.

Optional Feature:
- Macro: MEM_ARB_EXT_HALT_EN.
- When defined:
  - Extra input ext_halt and output core_halted.
  - While ext_halt=1: core_gnt is forced 0 and ext has absolute priority.
  - core_halted rises on the first cycle with ext_halt=1 and no core read response pending (owner tag != OWN_CORE). It falls in the same cycle ext_halt falls.
- When undefined: the ports are absent and behaviour is exactly as above.

Decomposition:
- Shared package: mem_addr_t with the MEM_B/H/W/BU/HU encodings (existing), word_t (existing), new enum arb_owner_t {OWN_NONE, OWN_CORE, OWN_EXT}, new function mem_aligned(addr, size).
- One natural sub-module, mem_arb_starve: saturating starvation counter producing ext_pri.

Test Plan:
- Core-only read of 0x100, MEM_W, mem_rdata=0xDEADBEEF → core_gnt=1 in cycle 0; mem_en=1, mem_addr=0x100; core_rvalid=1, rdata=0xDEADBEEF in cycle 1; ext_rvalid=0.
- core_req and ext_req held high, STARVE_LIMIT=8 → core granted cycles 0–7, ext_gnt=1 in cycle 8, starve_cnt=0 in cycle 9, core granted again in cycle 9.
- Core store of MEM_W to 0x102 → core_gnt=1, mem_en=0; core_err=1 in the next cycle only; no core_rvalid.
- Ext read at 0x40 in cycle 0, core read at 0x44 in cycle 1 → ext_rvalid in cycle 1 and core_rvalid in cycle 2, each with the matching data; never both valid in the same cycle.
- Core read granted, then rst_n=0 on the next edge → core_rvalid stays 0; all gnt, err and rvalid outputs are 0 while in reset; normal operation resumes the cycle after rst_n=1.
- MEM_ARB_EXT_HALT_EN: ext_halt=1 while a core read is in flight → core_halted=1 one cycle after the core_rvalid; core_gnt stays 0 while ext_halt=1 even with ext_req=0.
